// File: rtl/mini_micro_mc.sv
// Multi-cycle mini micro core: fetches 32-bit instructions over a req/valid
// handshake and executes them against a register file with NZCV flags.
module mini_micro_mc #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 4,
   parameter int PC_W   = 16,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [PC_W-1:0]   imem_addr,
   input  logic              imem_valid,
   input  logic [31:0]       imem_rdata,
   output logic [PC_W-1:0]   pc,
   output logic [3:0]        flags,
   output logic              halted,
   output logic              illegal,
   output logic [CNT_W-1:0]  retired,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   localparam int NREG  = 1 << REG_AW;
   localparam int SH_W  = $clog2(DATA_W);
   localparam int H_MSB = (DATA_W >= 16) ? 15 : DATA_W - 1;
   localparam int LDI_W = (DATA_W < 18) ? DATA_W : 18;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   state_t              state_r, state_nx_s;
   logic                imem_req_r;
   logic [31:0]         instr_r;
   logic [PC_W-1:0]     pc_r;
   logic [3:0]          flags_r, flags_nx_s;
   logic [CNT_W-1:0]    retired_r;
   logic                halted_r, illegal_r;
   logic [DATA_W-1:0]   regs_r [NREG];

   logic [4:0]          op_s;
   logic [REG_AW-1:0]   rd_s, rs1_s, rs2_s;
   logic [DATA_W-1:0]   a_s, b_s, add_b_s, res_s;
   logic [DATA_W:0]     sum_s;
   logic [SH_W-1:0]     sh_s, rol_amt_s;
   logic                sub_op_s, cin_s, ovf_s, wr_en_s, nz_en_s, c_nx_s, v_nx_s, illegal_op_s;

   // Next-state logic of the fetch/execute/halt sequencer
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_FETCH: begin
            if (imem_req_r && imem_valid) state_nx_s = ST_EXEC;
            else                          state_nx_s = ST_FETCH;
         end
         ST_EXEC: begin
            if (op_s == 5'd31) state_nx_s = ST_HALT;
            else               state_nx_s = ST_FETCH;
         end
         ST_HALT:  state_nx_s = ST_HALT;
         default:  state_nx_s = ST_FETCH;
      endcase
   end

   // Operand read and a single shared adder for ADD/ADC/SUB/SBC/CMP
   always_comb begin
      op_s      = instr_r[31:27];
      rd_s      = instr_r[18 +: REG_AW];
      rs1_s     = instr_r[9 +: REG_AW];
      rs2_s     = instr_r[0 +: REG_AW];
      a_s       = regs_r[rs1_s];
      b_s       = regs_r[rs2_s];
      sh_s      = b_s[SH_W-1:0];
      rol_amt_s = {SH_W{1'b0}} - sh_s;
      sub_op_s  = (op_s == 5'd7) || (op_s == 5'd8) || (op_s == 5'd18);
      add_b_s   = sub_op_s ? ~b_s : b_s;
      case (op_s)
         5'd5, 5'd7:  cin_s = flags_r[1];
         5'd8, 5'd18: cin_s = 1'b1;
         default:     cin_s = 1'b0;
      endcase
      sum_s = {1'b0, a_s} + {1'b0, add_b_s} + {{DATA_W{1'b0}}, cin_s};
      ovf_s = (a_s[DATA_W-1] == add_b_s[DATA_W-1]) && (sum_s[DATA_W-1] != a_s[DATA_W-1]);
      illegal_op_s = (op_s >= 5'd20) && (op_s <= 5'd30);
   end

   // Result mux and flag computation
   always_comb begin
      res_s   = {DATA_W{1'b0}};
      wr_en_s = 1'b0;
      nz_en_s = 1'b0;
      c_nx_s  = flags_r[1];
      v_nx_s  = flags_r[0];
      case (op_s)
         5'd1:  begin res_s = a_s & b_s; wr_en_s = 1'b1; nz_en_s = 1'b1; end
         5'd2:  begin res_s = a_s | b_s; wr_en_s = 1'b1; nz_en_s = 1'b1; end
         5'd3:  begin res_s = ~a_s;      wr_en_s = 1'b1; nz_en_s = 1'b1; end
         5'd4:  begin res_s = a_s ^ b_s; wr_en_s = 1'b1; nz_en_s = 1'b1; end
         5'd5, 5'd6, 5'd7, 5'd8, 5'd18: begin
            res_s   = sum_s[DATA_W-1:0];
            wr_en_s = (op_s != 5'd18);
            nz_en_s = 1'b1;
            c_nx_s  = sum_s[DATA_W];
            v_nx_s  = ovf_s;
         end
         5'd9:  begin res_s = a_s * b_s; wr_en_s = 1'b1; nz_en_s = 1'b1; end
         5'd10, 5'd12, 5'd13: begin
            case (op_s)
               5'd10:   res_s = a_s >> sh_s;
               5'd12:   res_s = DATA_W'($signed(a_s) >>> sh_s);
               default: res_s = (a_s >> sh_s) | (a_s << rol_amt_s);
            endcase
            wr_en_s = 1'b1;
            nz_en_s = 1'b1;
            // Right shifts all drop bit sh-1 last
            if (sh_s != {SH_W{1'b0}}) c_nx_s = a_s[sh_s - 1'b1];
            else                      c_nx_s = flags_r[1];
         end
         5'd11: begin
            res_s   = a_s << sh_s;
            wr_en_s = 1'b1;
            nz_en_s = 1'b1;
            if (sh_s != {SH_W{1'b0}}) c_nx_s = a_s[rol_amt_s];
            else                      c_nx_s = flags_r[1];
         end
         5'd14: begin res_s = DATA_W'(a_s[7:0]);              wr_en_s = 1'b1; nz_en_s = 1'b1; end
         5'd15: begin res_s = DATA_W'(a_s[H_MSB:0]);          wr_en_s = 1'b1; nz_en_s = 1'b1; end
         5'd16: begin res_s = DATA_W'($signed(a_s[7:0]));     wr_en_s = 1'b1; nz_en_s = 1'b1; end
         5'd17: begin res_s = DATA_W'($signed(a_s[H_MSB:0])); wr_en_s = 1'b1; nz_en_s = 1'b1; end
         5'd19: begin res_s = DATA_W'(instr_r[LDI_W-1:0]);    wr_en_s = 1'b1; end
         default: begin res_s = {DATA_W{1'b0}}; wr_en_s = 1'b0; end
      endcase
      if (nz_en_s) flags_nx_s = {res_s[DATA_W-1], (res_s == {DATA_W{1'b0}}), c_nx_s, v_nx_s};
      else         flags_nx_s = {flags_r[3:2], c_nx_s, v_nx_s};
   end

   // Architectural state: sequencer, fetch latch, register file, counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= ST_FETCH;
         imem_req_r <= 1'b0;
         instr_r    <= 32'd0;
         pc_r       <= {PC_W{1'b0}};
         flags_r    <= 4'd0;
         retired_r  <= {CNT_W{1'b0}};
         halted_r   <= 1'b0;
         illegal_r  <= 1'b0;
         for (int i = 0; i < NREG; i++) regs_r[i] <= {DATA_W{1'b0}};
      end else begin
         state_r    <= state_nx_s;
         imem_req_r <= (state_nx_s == ST_FETCH);
         if (state_r == ST_FETCH && imem_req_r && imem_valid) instr_r <= imem_rdata;
         if (state_r == ST_EXEC) begin
            retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
            flags_r   <= flags_nx_s;
            if (wr_en_s)      regs_r[rd_s] <= res_s;
            if (illegal_op_s) illegal_r <= 1'b1;
            if (op_s == 5'd31) halted_r <= 1'b1;
            else               pc_r <= pc_r + {{(PC_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign imem_req  = imem_req_r;
   assign imem_addr = pc_r;
   assign pc        = pc_r;
   assign flags     = flags_r;
   assign halted    = halted_r;
   assign illegal   = illegal_r;
   assign retired   = retired_r;
   assign dbg_data  = regs_r[dbg_addr];

endmodule

// File: tb/tb_mini_micro_mc.sv
// Self-checking bench for mini_micro_mc: directed sequences, a hand-derived
// vector table and randomized programs checked against a behavioural model.
module tb_mini_micro_mc;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_valid = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic [15:0] pc;
   logic [3:0]  flags;
   logic        halted, illegal;
   logic [31:0] retired;
   logic [3:0]  dbg_addr = 4'd0;
   logic [31:0] dbg_data;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [31:0] m_regs [16];
   logic [3:0]  m_flags;
   logic [15:0] m_pc;
   logic [31:0] m_ret;
   logic        m_halted, m_illegal;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic [31:0] exp_res;
      logic [3:0]  exp_flags;
   } vec_t;
   vec_t tbl [20];

   mini_micro_mc dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_valid(imem_valid), .imem_rdata(imem_rdata), .pc(pc), .flags(flags),
      .halted(halted), .illegal(illegal), .retired(retired),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] enc(input int op, input int rd, input int rs1, input int rs2);
      return {5'(op), 9'(rd), 9'(rs1), 9'(rs2)};
   endfunction

   function automatic logic [31:0] ldi(input int rd, input logic [17:0] imm);
      return {5'd19, 9'(rd), imm};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
      m_flags = 4'd0; m_pc = 16'd0; m_ret = 32'd0; m_halted = 1'b0; m_illegal = 1'b0;
   endtask

   function automatic logic ovf32(input longint v);
      return (v > 64'sd2147483647) || (v < -64'sd2147483648);
   endfunction

   // Behavioural reference: plain integer arithmetic, bit-at-a-time shifts
   task automatic model_exec(input logic [31:0] ins);
      logic [4:0]  op;
      logic [3:0]  rd, rs1, rs2;
      logic [31:0] a, b, r;
      logic        n, z, c, v, wr, nz;
      longint      s, sv, ci;
      op = ins[31:27]; rd = ins[21:18]; rs1 = ins[12:9]; rs2 = ins[3:0];
      a = m_regs[rs1]; b = m_regs[rs2];
      {n, z, c, v} = m_flags;
      r = 32'd0; wr = 1'b0; nz = 1'b0;
      case (op)
         5'd0: ;
         5'd1: begin r = a & b; wr = 1; nz = 1; end
         5'd2: begin r = a | b; wr = 1; nz = 1; end
         5'd3: begin r = ~a;    wr = 1; nz = 1; end
         5'd4: begin r = a ^ b; wr = 1; nz = 1; end
         5'd5, 5'd6: begin
            ci = (op == 5'd5 && c) ? 1 : 0;
            s  = longint'(a) + longint'(b) + ci;
            sv = longint'($signed(a)) + longint'($signed(b)) + ci;
            r = s[31:0]; c = (s > 64'sd4294967295); v = ovf32(sv); wr = 1; nz = 1;
         end
         5'd7, 5'd8, 5'd18: begin
            ci = (op == 5'd7 && !c) ? 1 : 0;
            s  = longint'(a) - longint'(b) - ci;
            sv = longint'($signed(a)) - longint'($signed(b)) - ci;
            r = s[31:0]; c = (s >= 0); v = ovf32(sv); wr = (op != 5'd18); nz = 1;
         end
         5'd9: begin r = a * b; wr = 1; nz = 1; end
         5'd10, 5'd11, 5'd12, 5'd13: begin
            r = a;
            for (int k = 0; k < int'(b[4:0]); k++) begin
               case (op)
                  5'd10:   begin c = r[0];  r = r >> 1; end
                  5'd11:   begin c = r[31]; r = r << 1; end
                  5'd12:   begin c = r[0];  r = {r[31], r[31:1]}; end
                  default: begin c = r[0];  r = {r[0], r[31:1]}; end
               endcase
            end
            wr = 1; nz = 1;
         end
         5'd14: begin r = {24'h0, a[7:0]};         wr = 1; nz = 1; end
         5'd15: begin r = {16'h0, a[15:0]};        wr = 1; nz = 1; end
         5'd16: begin r = {{24{a[7]}}, a[7:0]};    wr = 1; nz = 1; end
         5'd17: begin r = {{16{a[15]}}, a[15:0]};  wr = 1; nz = 1; end
         5'd19: begin r = {14'h0, ins[17:0]};      wr = 1; end
         5'd31: m_halted = 1'b1;
         default: m_illegal = 1'b1;
      endcase
      if (nz) begin n = r[31]; z = (r == 32'd0); end
      m_flags = {n, z, c, v};
      if (wr) m_regs[rd] = r;
      m_ret++;
      if (op != 5'd31) m_pc++;
   endtask

   task automatic run_instr(input logic [31:0] ins, input int waits);
      int n = 0;
      logic [3:0] rd;
      rd = ins[21:18];
      while (!imem_req && n < 20) begin @(posedge clk); #1; n++; end
      if (!imem_req) begin check("req_timeout", imem_req, 1); return; end
      check("fetch_addr", imem_addr, m_pc);
      for (int w = 0; w < waits; w++) begin
         @(posedge clk); #1;
         check("wait_req", imem_req, 1);
         check("wait_addr", imem_addr, m_pc);
         check("wait_ret", retired, m_ret);
      end
      imem_valid = 1'b1; imem_rdata = ins;
      @(posedge clk); #1;
      imem_valid = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
      check("exec_req", imem_req, 0);
      dbg_addr = rd; #1;
      check("dbg_old", dbg_data, m_regs[rd]);
      @(posedge clk); #1;
      imem_valid = 1'b0;
      model_exec(ins);
      check("pc", pc, m_pc);
      check("flags", flags, m_flags);
      check("retired", retired, m_ret);
      check("halted", halted, m_halted);
      check("illegal", illegal, m_illegal);
      #1;
      check("reg_rd", dbg_data, m_regs[rd]);
   endtask

   task automatic read_reg(input int r, output logic [31:0] val);
      dbg_addr = 4'(r); #1; val = dbg_data;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_req"}, imem_req, 0);
      check({tag, "_addr"}, imem_addr, 0);
      check({tag, "_pc"}, pc, 0);
      check({tag, "_flags"}, flags, 0);
      check({tag, "_halted"}, halted, 0);
      check({tag, "_illegal"}, illegal, 0);
      check({tag, "_retired"}, retired, 0);
      check({tag, "_dbg"}, dbg_data, 0);
   endtask

   task automatic check_regs(input string tag);
      logic [31:0] val;
      for (int i = 0; i < 16; i++) begin
         read_reg(i, val);
         check(tag, val, m_regs[i]);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0; imem_valid = 1'b0;
      @(posedge clk); #1;
      check_zero("rst");
      @(posedge clk); #1;
      rst = 1'b1;
      model_reset();
   endtask

   task automatic load_reg(input int r, input logic [31:0] val);
      if (val[31:18] == 14'd0) run_instr(ldi(r, val[17:0]), 0);
      else begin
         run_instr(ldi(r, {4'd0, val[31:18]}), 0);
         run_instr(ldi(15, 18'd18), 0);
         run_instr(enc(11, r, r, 15), 0);
         run_instr(ldi(14, val[17:0]), 0);
         run_instr(enc(2, r, r, 14), 0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] val;
      int cyc0, n;
      tbl[0]  = '{5'd6,  32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 4'b1001};
      tbl[1]  = '{5'd8,  32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 4'b0110};
      tbl[2]  = '{5'd7,  32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 4'b1000};
      tbl[3]  = '{5'd12, 32'h80000000, 32'h00000004, 1'b1, 32'hF8000000, 4'b1000};
      tbl[4]  = '{5'd13, 32'h00000001, 32'h00000001, 1'b0, 32'h80000000, 4'b1010};
      tbl[5]  = '{5'd11, 32'h80000001, 32'h00000001, 1'b0, 32'h00000002, 4'b0010};
      tbl[6]  = '{5'd10, 32'h00000003, 32'h00000000, 1'b1, 32'h00000003, 4'b0010};
      tbl[7]  = '{5'd5,  32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 4'b0110};
      tbl[8]  = '{5'd9,  32'h00010000, 32'h00010001, 1'b1, 32'h00010000, 4'b0010};
      tbl[9]  = '{5'd16, 32'h00000080, 32'h00000000, 1'b0, 32'hFFFFFF80, 4'b1000};
      tbl[10] = '{5'd15, 32'hFFFF8001, 32'h00000000, 1'b1, 32'h00008001, 4'b0010};
      tbl[11] = '{5'd4,  32'hF0F0F0F0, 32'hF0F0F0F0, 1'b0, 32'h00000000, 4'b0100};
      tbl[12] = '{5'd3,  32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 4'b1010};
      tbl[13] = '{5'd8,  32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 4'b0011};
      tbl[14] = '{5'd10, 32'h80000000, 32'h0000001F, 1'b0, 32'h00000001, 4'b0000};
      tbl[15] = '{5'd17, 32'h00018000, 32'h00000000, 1'b1, 32'hFFFF8000, 4'b1010};
      tbl[16] = '{5'd2,  32'h0000000F, 32'h000000F0, 1'b0, 32'h000000FF, 4'b0000};
      tbl[17] = '{5'd1,  32'h0000FF00, 32'h00000FF0, 1'b1, 32'h00000F00, 4'b0010};
      tbl[18] = '{5'd14, 32'h000001FF, 32'h00000000, 1'b0, 32'h000000FF, 4'b0000};
      tbl[19] = '{5'd11, 32'h00000001, 32'h00000005, 1'b1, 32'h00000020, 4'b0000};

      model_reset();
      do_reset();

      // Zero-wait three-instruction program: two cycles per instruction
      n = 0;
      while (!imem_req && n < 20) begin @(posedge clk); #1; n++; end
      cyc0 = cyc;
      run_instr(ldi(1, 18'd5), 0);
      run_instr(ldi(2, 18'd3), 0);
      run_instr(enc(6, 3, 1, 2), 0);
      check("tp1_cycles", cyc - cyc0, 6);
      read_reg(3, val);
      check("tp1_r3", val, 32'd8);
      check("tp1_flags", flags, 4'b0000);
      check("tp1_ret", retired, 3);
      check("tp1_pc", pc, 3);

      // SUB to zero, then SBC with carry set
      run_instr(ldi(1, 18'd0), 0);
      run_instr(enc(8, 4, 1, 1), 0);
      read_reg(4, val);
      check("tp2_r4", val, 32'd0);
      check("tp2_flags_sub", flags, 4'b0110);
      run_instr(ldi(2, 18'd1), 0);
      run_instr(enc(7, 5, 1, 2), 0);
      read_reg(5, val);
      check("tp2_r5", val, 32'hFFFFFFFF);
      check("tp2_flags_sbc", flags, 4'b1000);

      // Long memory wait: request and address held, no retirement
      run_instr(enc(2, 6, 2, 2), 5);

      // Vector table
      for (int i = 0; i < 20; i++) begin
         load_reg(1, tbl[i].a);
         load_reg(2, tbl[i].b);
         if (tbl[i].cin) run_instr(enc(18, 0, 0, 0), 0);
         else begin
            run_instr(ldi(13, 18'd1), 0);
            run_instr(enc(18, 0, 0, 13), 0);
         end
         run_instr(enc(tbl[i].op, 3, 1, 2), 0);
         read_reg(3, val);
         check($sformatf("tbl%0d_res", i), val, tbl[i].exp_res);
         check($sformatf("tbl%0d_flags", i), flags, tbl[i].exp_flags);
      end

      // Randomized programs against the model, with garbage upper field bits
      for (int i = 0; i < 300; i++) begin
         int op;
         op = ($urandom_range(0, 15) == 0) ? int'($urandom_range(20, 30)) : int'($urandom_range(0, 19));
         run_instr({5'(op), 5'($urandom), 4'($urandom_range(1, 12)), 9'($urandom), 9'($urandom)},
                   int'($urandom_range(0, 2)));
      end
      check_regs("rand_regs");

      // Asynchronous reset in the middle of a fetch
      n = 0;
      while (!imem_req && n < 20) begin @(posedge clk); #1; n++; end
      imem_valid = 1'b0;
      #2 rst = 1'b0;
      #1 check_zero("midrst");
      @(posedge clk); #1;
      rst = 1'b1;
      model_reset();
      check("midrst_norq", imem_req, 0);
      check_regs("midrst_regs");
      run_instr(ldi(1, 18'd7), 0);

      // Illegal opcode then HALT from a clean reset
      do_reset();
      run_instr(enc(25, 1, 2, 3), 0);
      run_instr(enc(31, 0, 0, 0), 0);
      check("halt_illegal", illegal, 1);
      check("halt_halted", halted, 1);
      check("halt_pc", pc, 1);
      check("halt_ret", retired, 2);
      check_regs("halt_regs");
      for (int i = 0; i < 20; i++) begin
         imem_valid = 1'b1; imem_rdata = ldi(1, 18'h3FFFF);
         @(posedge clk); #1;
         check("halt_req", imem_req, 0);
         check("halt_ret_hold", retired, 2);
         check("halt_pc_hold", pc, 1);
      end
      imem_valid = 1'b0;

      // Reset while halted, then resume from address 0
      do_reset();
      run_instr(ldi(2, 18'd9), 0);
      check("resume_pc", pc, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
